// File: rtl/pc_sequencer_if.sv
// Fetch-side bus bundle for pc_sequencer: imem port, decode port, branch port.
// The master modport is the sequencer; the slave modport is its environment.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            stall;
    logic            br_valid;
    logic            NextPcSrc;
    logic [XLEN-1:0] BrTarget;
    logic            flush;
    logic            misalign_err;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_rsp_valid,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        input  stall,
        input  br_valid,
        input  NextPcSrc,
        input  BrTarget,
        output flush,
        output misalign_err
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_rsp_valid,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output stall,
        output br_valid,
        output NextPcSrc,
        output BrTarget,
        input  flush,
        input  misalign_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC owner and fetch sequencer: REQ -> WAIT -> HOLD with redirect/kill.
// Optional BRANCH_STATS_EN adds redirect_cnt and kill_cnt outputs.
module pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef BRANCH_STATS_EN
    output logic [31:0]          redirect_cnt,
    output logic [31:0]          kill_cnt,
`endif
    pc_sequencer_if.master       bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            flush_q, flush_d;
    logic            mis_q, mis_d;

    logic taken;
    logic aligned;
    logic redir;
    logic drop_rsp;

    assign taken    = bus.br_valid & bus.NextPcSrc;
    assign aligned  = (bus.BrTarget[1:0] == 2'b00);
    assign redir    = taken & aligned;
    assign drop_rsp = (state_q == S_WAIT) & bus.imem_rsp_valid
                    & (kill_q | redir);

    assign bus.imem_req_valid = (state_q == S_REQ);
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.flush          = flush_q;
    assign bus.misalign_err   = mis_q;

    // Next-state: sequential fetch first, then an accepted redirect overrides.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        flush_d      = 1'b0;
        mis_d        = taken & ~aligned;

        case (state_q)
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d       = bus.imem_rdata;
                        inst_pc_d    = req_pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = req_pc_q + XLEN'(4);
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!bus.stall) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redir) begin
            pc_d         = bus.BrTarget;
            flush_d      = 1'b1;
            inst_valid_d = 1'b0;
            inst_d       = inst_q;
            inst_pc_d    = inst_pc_q;
            // A request is (or is about to be) outstanding with no
            // response yet: wait for it and throw it away.
            if ((state_q == S_WAIT && !bus.imem_rsp_valid) ||
                (state_q == S_REQ && bus.imem_req_ready)) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_REQ;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            flush_q      <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            flush_q      <= flush_d;
            mis_q        <= mis_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] redir_cnt_q;
    logic [31:0] kill_cnt_q;

    // Event counters for accepted redirects and dropped responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (redir)
                redir_cnt_q <= redir_cnt_q + 32'd1;
            if (drop_rsp)
                kill_cnt_q <= kill_cnt_q + 32'd1;
        end
    end

    assign redirect_cnt = redir_cnt_q;
    assign kill_cnt     = kill_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop_rsp;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Inputs change #1 after posedge; outputs are checked there too.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

`ifdef BRANCH_STATS_EN
    logic [31:0] redirect_cnt;
    logic [31:0] kill_cnt;
`endif

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef BRANCH_STATS_EN
        .redirect_cnt (redirect_cnt),
        .kill_cnt     (kill_cnt),
`endif
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic br(input logic v, input logic t, input logic [31:0] a);
        bus.br_valid  = v;
        bus.NextPcSrc = t;
        bus.BrTarget  = a;
    endtask

    // REQ at pc -> WAIT -> response same cycle -> HOLD with inst at pc.
    task automatic fetch_one(input logic [31:0] pc);
        chk("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("req_addr", bus.imem_addr, pc);
        bus.imem_req_ready = 1'b1;
        tick();
        chk("wait_noreq", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("wait_noinst", {31'd0, bus.inst_valid}, 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata     = word_of(pc);
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata     = 32'hDEAD_BEEF;
        chk("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("hold_pc", bus.inst_pc, pc);
        chk("hold_inst", bus.inst, word_of(pc));
    endtask

    task automatic release_one();
        bus.stall = 1'b0;
        tick();
        chk("rel_invalid", {31'd0, bus.inst_valid}, 32'd0);
    endtask

    initial begin
        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata     = '0;
        bus.stall          = 1'b0;
        br(1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;

        chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_pc", bus.inst_pc, 32'd0);
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_mis", {31'd0, bus.misalign_err}, 32'd0);

        fetch_one(32'h0);
        release_one();
        fetch_one(32'h4);
        release_one();
        fetch_one(32'h8);

        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
            chk("stall_pc", bus.inst_pc, 32'h8);
            chk("stall_inst", bus.inst, word_of(32'h8));
            chk("stall_noreq", {31'd0, bus.imem_req_valid}, 32'd0);
        end
        release_one();
        fetch_one(32'hC);
        release_one();

        // Redirect while waiting; the stale response comes 2 cycles later.
        chk("t3_addr", bus.imem_addr, 32'h10);
        tick();
        br(1'b1, 1'b1, 32'h100);
        tick();
        br(1'b0, 1'b0, '0);
        chk("t3_flush1", {31'd0, bus.flush}, 32'd1);
        chk("t3_noreq", {31'd0, bus.imem_req_valid}, 32'd0);
        tick();
        chk("t3_flush0", {31'd0, bus.flush}, 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata     = 32'h1111_1111;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("t3_dropped", {31'd0, bus.inst_valid}, 32'd0);
        fetch_one(32'h100);
        release_one();
`ifdef BRANCH_STATS_EN
        chk("t3_rcnt", redirect_cnt, 32'd1);
        chk("t3_kcnt", kill_cnt, 32'd1);
`endif

        // Redirect in the same cycle as the response.
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata     = 32'h2222_2222;
        br(1'b1, 1'b1, 32'h200);
        tick();
        bus.imem_rsp_valid = 1'b0;
        br(1'b0, 1'b0, '0);
        chk("t4_flush", {31'd0, bus.flush}, 32'd1);
        chk("t4_noinst", {31'd0, bus.inst_valid}, 32'd0);
        fetch_one(32'h200);
        release_one();
`ifdef BRANCH_STATS_EN
        chk("t4_rcnt", redirect_cnt, 32'd2);
        chk("t4_kcnt", kill_cnt, 32'd2);
`endif

        // Misaligned target is ignored; sequential fetch carries on.
        chk("t5_addr", bus.imem_addr, 32'h204);
        br(1'b1, 1'b1, 32'h102);
        tick();
        br(1'b0, 1'b0, '0);
        chk("t5_mis", {31'd0, bus.misalign_err}, 32'd1);
        chk("t5_flush", {31'd0, bus.flush}, 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata     = word_of(32'h204);
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("t5_mis0", {31'd0, bus.misalign_err}, 32'd0);
        chk("t5_pc", bus.inst_pc, 32'h204);
        release_one();
        chk("t5_next", bus.imem_addr, 32'h208);

        // Redirect in REQ without ready, then PC wrap.
        bus.imem_req_ready = 1'b0;
        br(1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        br(1'b0, 1'b0, '0);
        chk("wr_flush", {31'd0, bus.flush}, 32'd1);
        fetch_one(32'hFFFF_FFFC);
        release_one();
        fetch_one(32'h0);

        // Redirect squashes a held instruction.
        bus.stall = 1'b1;
        br(1'b1, 1'b1, 32'h300);
        tick();
        br(1'b0, 1'b0, '0);
        chk("sq_invalid", {31'd0, bus.inst_valid}, 32'd0);
        chk("sq_flush", {31'd0, bus.flush}, 32'd1);
        chk("sq_addr", bus.imem_addr, 32'h300);
        bus.stall = 1'b0;

        // Not-taken branch result changes nothing.
        bus.imem_req_ready = 1'b0;
        br(1'b1, 1'b0, 32'h500);
        tick();
        br(1'b0, 1'b0, '0);
        chk("nt_flush", {31'd0, bus.flush}, 32'd0);
        chk("nt_addr", bus.imem_addr, 32'h300);
`ifdef BRANCH_STATS_EN
        chk("nt_rcnt", redirect_cnt, 32'd4);
        chk("nt_kcnt", kill_cnt, 32'd2);
`endif

        // Reset while waiting, then a late response.
        bus.imem_req_ready = 1'b1;
        tick();
        chk("r_wait", {31'd0, bus.imem_req_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata     = 32'h3333_3333;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("r_noinst", {31'd0, bus.inst_valid}, 32'd0);
        chk("r_addr", bus.imem_addr, 32'h0);
        chk("r_req", {31'd0, bus.imem_req_valid}, 32'd1);
`ifdef BRANCH_STATS_EN
        chk("r_rcnt", redirect_cnt, 32'd0);
        chk("r_kcnt", kill_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
